mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single synchronous-read `memory` port between `NUM_REQ` independent requesters (e.g. testbench driver and a DMA/loader). Each requester issues one read or write at a time over a valid/ready request channel and receives a one-cycle response pulse. The block sits directly in front of `memory`: it owns the memory's `address`, `data_in`, `write` and `enable` pins and returns the memory's `data_out`.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 8: memory address width.
- `DATA_WIDTH`, 8: memory data width.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ×ADDR_WIDTH: packed per-requester address.
- `req_wdata` in NUM_REQ×DATA_WIDTH: packed per-requester write data.
- `req_ready` out NUM_REQ: one-hot grant; request accepted on this edge.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, qualified by `rsp_valid`.
- `mem_address` out ADDR_WIDTH: to memory `address`.
- `mem_data_in` out DATA_WIDTH: to memory `data_in`.
- `mem_write` out 1: to memory `write`.
- `mem_enable` out 1: to memory `enable`.
- `mem_data_out` in DATA_WIDTH: from memory `data_out` (valid the cycle after a read enable).

## Operation
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE: if any `req_valid`, arbiter selects winner; `req_ready[winner]`=1 combinationally; on the edge, latch owner index, write flag, address, wdata; go ACCESS. Else stay IDLE.
- ACCESS: `mem_enable`=1, `mem_write`/`mem_address`/`mem_data_in` from latched command (registered outputs); go COMPLETE.
- COMPLETE: `rsp_valid[owner]`=1; `rsp_rdata` = `mem_data_out` for reads, 0 for writes; update round-robin pointer to owner; go IDLE.
- Round-robin: search starts at pointer+1 modulo NUM_REQ; reset pointer = NUM_REQ-1 so requester 0 wins first.
- Requester must hold `req_valid`/command stable until `req_ready`; dropping `req_valid` before grant withdraws the request without side effect.
- `req_ready` is 0 in ACCESS and COMPLETE; at most one bit set ever.
- `req_valid` from the owner during COMPLETE is not accepted until the following IDLE cycle.

## Timing
- Grant in cycle T (IDLE) → `mem_enable` in T+1 → `rsp_valid` in T+2; next grant no earlier than T+3.
- Throughput: one access per 3 cycles; read and write latency identical.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `mem_enable`=0, `mem_write`=0, `mem_address`=0, `mem_data_in`=0; state IDLE.
- Reset asserted mid-transaction: outputs go to reset values immediately (asynchronous); in-flight access dropped, no `rsp_valid` issued; a write in ACCESS may or may not have reached memory.
- All requesters valid continuously: grants rotate 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ grants.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; pointer logic removed.
- Undefined (default): round-robin as above.

## Structure
- `mem_arb_pkg`: state enum `mem_arb_state_e` (IDLE, ACCESS, COMPLETE), default width constants.
- One sub-module `rr_pick`: combinational one-hot selector given request vector and pointer (NUM_REQ parameter); bypassed under `MEM_ARB_FIXED_PRIO_EN`.

## Test plan
- Single write then read, requester 0: write addr 0x12 data 0xA5, read 0x12 → `mem_enable` one cycle each, read `rsp_rdata`=0xA5 two cycles after grant.
- Both requesters valid continuously, NUM_REQ=2, four transactions → grant order 0,1,0,1; grants spaced 3 cycles.
- Requester 1 only: write addr 0xFF data 0x3C, reads back 0x3C; requester 0 `rsp_valid` never set.
- Reset asserted in ACCESS → `mem_enable` drops same cycle, no `rsp_valid`; after release, next grant goes to requester 0.
- Requester drops `req_valid` while other owns bus → never granted, no memory access issued for it.
- `MEM_ARB_FIXED_PRIO_EN` defined, both continuously valid → requester 0 granted every time, requester 1 starved.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } mem_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker: the first set request after ptr (wrapping) wins.
module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        // Walk from farthest to nearest so the closest requester after ptr overwrites.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                grant               = '0;
                grant[IDX_W'(idx)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port among NUM_REQ requesters, one access per 3 cycles.
// Define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic [DATA_WIDTH-1:0]                mem_data_in,
    output logic                                 mem_write,
    output logic                                 mem_enable,
    input  logic [DATA_WIDTH-1:0]                mem_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    mem_arb_state_e     state_q, state_d;
    logic [IDX_W-1:0]   owner_q;
    logic               wr_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Resetting to the last index makes requester 0 the first winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr_q <= IDX_W'(NUM_REQ - 1);
        else if (state_q == COMPLETE)
            ptr_q <= owner_q;
    end
`endif

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) grant_idx = IDX_W'(i);
    end

    assign accept = (state_q == IDLE) && (|req_valid) && !reset;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready = grant;
                    state_d   = ACCESS;
                end
            end
            ACCESS: state_d = COMPLETE;
            COMPLETE: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_rdata          = wr_q ? '0 : mem_data_out;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory pins are loaded at grant so they are registered for the ACCESS cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            wr_q        <= 1'b0;
            mem_enable  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q     <= grant_idx;
                wr_q        <= req_write[grant_idx];
                mem_enable  <= 1'b1;
                mem_write   <= req_write[grant_idx];
                mem_address <= req_addr[grant_idx];
                mem_data_in <= req_wdata[grant_idx];
            end else begin
                mem_enable <= 1'b0;
                mem_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_write, req_ready, rsp_valid;
    logic [1:0][7:0]  req_addr, req_wdata;
    logic [7:0]       rsp_rdata, mem_address, mem_data_in, mem_data_out;
    logic             mem_write, mem_enable;

    always #5 clock = ~clock;

    mem_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_enable(mem_enable), .mem_data_out(mem_data_out)
    );

    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_write) mem[mem_address] <= mem_data_in;
            else           mem_data_out     <= mem[mem_address];
        end
    end

    typedef struct { int who; logic [7:0] data; } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;
    int   gnt_who[$];
    int   gnt_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: logs grants and pops the scoreboard on every response pulse.
    always @(negedge clock) begin
        if (req_ready != 2'b00) begin
            chk("ready_onehot", 32'($countones(req_ready)), 1);
            gnt_who.push_back(req_ready[1] ? 1 : 0);
            gnt_cyc.push_back(cyc);
        end
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid %b with nothing outstanding", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_valid", rsp_valid, 1 << mon_e.who);
                chk("rsp_rdata", rsp_rdata, mon_e.data);
            end
        end
    end

    task automatic issue(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd);
        int   n = 0;
        rsp_t e;
        @(posedge clock); #1;
        req_valid[r] = 1'b1; req_write[r] = wr; req_addr[r] = a; req_wdata[r] = d;
        forever begin
            @(negedge clock);
            if (req_ready[r]) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout: requester %0d never granted", r);
                req_valid[r] = 1'b0;
                return;
            end
        end
        e.who  = r;
        e.data = wr ? 8'h00 : exp_rd;
        exp_q.push_back(e);
        @(posedge clock); #1;
        req_valid[r] = 1'b0;
        @(negedge clock);
        chk("acc_enable", mem_enable, 1);
        chk("acc_write", mem_write, wr);
        chk("acc_addr", mem_address, a);
        if (wr) chk("acc_wdata", mem_data_in, d);
        @(negedge clock);
        chk("done_enable", mem_enable, 0);
        chk("rsp_pulse", rsp_valid[r], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        req_valid = 2'b11; req_write = 2'b11; req_addr = '0; req_wdata = '1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_enable", mem_enable, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        req_valid = 2'b00;
        @(posedge clock); #1 reset = 1'b0;

        // Requester 0 write then read-back
        issue(0, 1'b1, 8'h12, 8'hA5, 8'h00);
        issue(0, 1'b0, 8'h12, 8'h00, 8'hA5);

        // Requester 1 alone at the top address
        gnt_who.delete(); gnt_cyc.delete();
        issue(1, 1'b1, 8'hFF, 8'h3C, 8'h00);
        issue(1, 1'b0, 8'hFF, 8'h00, 8'h3C);
        chk("r1_only_count", gnt_who.size(), 2);
        chk("r1_only_g0", gnt_who[0], 1);
        chk("r1_only_g1", gnt_who[1], 1);

        // Both continuously valid: four transactions
        gnt_who.delete(); gnt_cyc.delete();
        fork
            begin
                issue(0, 1'b1, 8'h30, 8'h5A, 8'h00);
                issue(0, 1'b0, 8'h30, 8'h00, 8'h5A);
            end
            begin
                issue(1, 1'b1, 8'h31, 8'hC3, 8'h00);
                issue(1, 1'b0, 8'h31, 8'h00, 8'hC3);
            end
        join
        chk("both_count", gnt_who.size(), 4);
        for (int i = 0; i < 4; i++) chk("both_order", gnt_who[i], exp_order[i]);
        for (int i = 1; i < 4; i++) chk("both_spacing", gnt_cyc[i] - gnt_cyc[i-1], 3);

        // Reset during ACCESS of requester 1, with pointer last left on requester 0
        issue(0, 1'b0, 8'h30, 8'h00, 8'h5A);
        @(posedge clock); #1;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h31;
        for (int n = 0; n < 50 && !req_ready[1]; n++) @(negedge clock);
        chk("pre_rst_grant", req_ready[1], 1);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        chk("pre_rst_enable", mem_enable, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_enable", mem_enable, 0);
        chk("mid_rst_write", mem_write, 0);
        chk("mid_rst_addr", mem_address, 0);
        repeat (2) @(negedge clock);
        chk("mid_rst_rsp", rsp_valid, 0);
        @(posedge clock); #1 reset = 1'b0;
        gnt_who.delete(); gnt_cyc.delete();
        fork
            issue(0, 1'b0, 8'h30, 8'h00, 8'h5A);
            issue(1, 1'b0, 8'h31, 8'h00, 8'hC3);
        join
        chk("post_rst_first", gnt_who[0], 0);
        chk("post_rst_second", gnt_who[1], 1);

        // Requester 0 withdraws while requester 1 owns the bus
        gnt_who.delete(); gnt_cyc.delete();
        fork
            issue(1, 1'b1, 8'h50, 8'h99, 8'h00);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clock);
                    if (req_ready[1]) break;
                end
                @(posedge clock); #1;
                req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h51; req_wdata[0] = 8'hEE;
                @(negedge clock);
                chk("withdraw_ready_acc", req_ready[0], 0);
                @(negedge clock);
                chk("withdraw_ready_cmp", req_ready[0], 0);
                req_valid[0] = 1'b0;
            end
        join
        issue(1, 1'b0, 8'h51, 8'h00, 8'h00);
        chk("withdraw_count", gnt_who.size(), 2);
        chk("withdraw_g0", gnt_who[0], 1);
        chk("withdraw_g1", gnt_who[1], 1);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
